// File: rtl/eq_pkg.sv
// Shared sizes, sample types and the output saturation helper for the
// single-tap complex channel equalizer.
package eq_pkg;

   localparam int LANES       = 4;
   localparam int SW          = 16;
   localparam int TRAIN_BEATS = 16;
   localparam int OUT_SHIFT   = 15;
   localparam int ACC_W       = 23;
   localparam int PROD_W      = 32;

   // Averaging over LANES*TRAIN_BEATS samples reduces to a plain right shift.
   localparam int TRAIN_SHIFT = $clog2(LANES * TRAIN_BEATS);
   localparam int CNT_W       = $clog2(TRAIN_BEATS + 1);

   localparam logic [CNT_W-1:0] TRAIN_CNT      = CNT_W'(TRAIN_BEATS);
   localparam logic [CNT_W-1:0] LAST_TRAIN_CNT = CNT_W'(TRAIN_BEATS - 1);

   localparam logic signed [PROD_W:0] SAT_MAX = 33'sd32767;
   localparam logic signed [PROD_W:0] SAT_MIN = -33'sd32768;

   typedef struct packed {
      logic signed [SW-1:0] q;
      logic signed [SW-1:0] i;
   } cplx_t;

   typedef cplx_t beat_t [LANES];

   function automatic logic signed [SW-1:0] sat16(input logic signed [PROD_W:0] v);
      if (v > SAT_MAX) begin
         return 16'sh7FFF;
      end else if (v < SAT_MIN) begin
         return 16'sh8000;
      end else begin
         return $signed(v[SW-1:0]);
      end
   endfunction

endpackage

// File: rtl/eq_cmult_conj.sv
// One lane of y = sat16((x * conj(h)) >>> OUT_SHIFT) as a two-stage pipeline:
// stage 1 registers the four partial products, stage 2 the saturated result.
module eq_cmult_conj
   import eq_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_en,
   input  cplx_t i_x,
   input  cplx_t i_h,
   output cplx_t o_y
);

   logic signed [PROD_W-1:0] w_xI;
   logic signed [PROD_W-1:0] w_xQ;
   logic signed [PROD_W-1:0] w_hI;
   logic signed [PROD_W-1:0] w_hQ;

   logic signed [PROD_W-1:0] r_pIhI;
   logic signed [PROD_W-1:0] r_pQhQ;
   logic signed [PROD_W-1:0] r_pQhI;
   logic signed [PROD_W-1:0] r_pIhQ;
   logic                     r_en1;

   logic signed [PROD_W:0]   w_sumI;
   logic signed [PROD_W:0]   w_sumQ;
   logic signed [PROD_W:0]   w_shI;
   logic signed [PROD_W:0]   w_shQ;

   cplx_t                    r_y;

   assign w_xI = PROD_W'($signed(i_x.i));
   assign w_xQ = PROD_W'($signed(i_x.q));
   assign w_hI = PROD_W'($signed(i_h.i));
   assign w_hQ = PROD_W'($signed(i_h.q));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_en1  <= 1'b0;
         r_pIhI <= '0;
         r_pQhQ <= '0;
         r_pQhI <= '0;
         r_pIhQ <= '0;
      end else begin
         r_en1 <= i_en;
         if (i_en) begin
            r_pIhI <= w_xI * w_hI;
            r_pQhQ <= w_xQ * w_hQ;
            r_pQhI <= w_xQ * w_hI;
            r_pIhQ <= w_xI * w_hQ;
         end
      end
   end

   // Sign-extend to 33 bits so -32768*-32768 summed twice cannot wrap.
   assign w_sumI = $signed({r_pIhI[PROD_W-1], r_pIhI}) + $signed({r_pQhQ[PROD_W-1], r_pQhQ});
   assign w_sumQ = $signed({r_pQhI[PROD_W-1], r_pQhI}) - $signed({r_pIhQ[PROD_W-1], r_pIhQ});
   assign w_shI  = w_sumI >>> OUT_SHIFT;
   assign w_shQ  = w_sumQ >>> OUT_SHIFT;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_y <= '0;
      end else if (r_en1) begin
         r_y.i <= sat16(w_shI);
         r_y.q <= sat16(w_shQ);
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/design1_wrapper.sv
// Streaming single-tap complex equalizer: averages each frame's training field
// into h, then multiplies every payload sample by conj(h) across all lanes.
module design1_wrapper
   import eq_pkg::*;
(
   input  logic                    s_axis_aclk_0,
   input  logic                    s_axis_areset_0,
   input  logic [LANES*2*SW-1:0]   s_axis_0_tdata,
   input  logic [7:0]              s_axis_0_tid,
   input  logic                    s_axis_0_tlast,
   input  logic [7:0]              s_axis_0_tuser,
   input  logic                    s_axis_0_tvalid,
   output logic [LANES*2*SW-1:0]   m_axis_0_tdata,
   output logic [7:0]              m_axis_0_tid,
   output logic                    m_axis_0_tlast,
   output logic [7:0]              m_axis_0_tuser,
   output logic                    m_axis_0_tvalid,
   output logic [31:0]             eq_h,
   output logic                    eq_h_valid
);

   beat_t                   w_x;
   beat_t                   w_y;

   logic [CNT_W-1:0]        r_cnt;
   logic signed [ACC_W-1:0] r_accI;
   logic signed [ACC_W-1:0] r_accQ;
   logic signed [ACC_W-1:0] w_beatI;
   logic signed [ACC_W-1:0] w_beatQ;
   logic signed [ACC_W-1:0] w_newI;
   logic signed [ACC_W-1:0] w_newQ;
   cplx_t                   r_h;
   logic                    r_hValid;

   logic                    w_train;
   logic                    w_payload;
   logic                    w_trainDone;

   logic                    r_vld1;
   logic                    r_vld2;
   logic                    r_last1;
   logic                    r_last2;
   logic [7:0]              r_id1;
   logic [7:0]              r_id2;
   logic [7:0]              r_user1;
   logic [7:0]              r_user2;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         w_x[k] = s_axis_0_tdata[2*SW*k +: 2*SW];
      end
   end

   always_comb begin
      w_beatI = '0;
      w_beatQ = '0;
      for (int k = 0; k < LANES; k++) begin
         w_beatI = w_beatI + ACC_W'($signed(w_x[k].i));
         w_beatQ = w_beatQ + ACC_W'($signed(w_x[k].q));
      end
   end

   assign w_newI = r_accI + w_beatI;
   assign w_newQ = r_accQ + w_beatQ;

   // The counter saturates at TRAIN_CNT, so "not yet saturated" means training.
   assign w_train     = s_axis_0_tvalid && (r_cnt != TRAIN_CNT);
   assign w_payload   = s_axis_0_tvalid && (r_cnt == TRAIN_CNT);
   assign w_trainDone = w_train && !s_axis_0_tlast && (r_cnt == LAST_TRAIN_CNT);

   always_ff @(posedge s_axis_aclk_0 or posedge s_axis_areset_0) begin
      if (s_axis_areset_0) begin
         r_cnt <= '0;
      end else if (s_axis_0_tvalid) begin
         if (s_axis_0_tlast) begin
            r_cnt <= '0;
         end else if (r_cnt != TRAIN_CNT) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // A tlast inside training aborts the estimate; h keeps its previous value.
   always_ff @(posedge s_axis_aclk_0 or posedge s_axis_areset_0) begin
      if (s_axis_areset_0) begin
         r_accI   <= '0;
         r_accQ   <= '0;
         r_h      <= '0;
         r_hValid <= 1'b0;
      end else if (w_train) begin
         if (w_trainDone) begin
            r_h.i    <= w_newI[TRAIN_SHIFT +: SW];
            r_h.q    <= w_newQ[TRAIN_SHIFT +: SW];
            r_hValid <= 1'b1;
            r_accI   <= '0;
            r_accQ   <= '0;
         end else if (s_axis_0_tlast) begin
            r_accI <= '0;
            r_accQ <= '0;
         end else begin
            r_accI <= w_newI;
            r_accQ <= w_newQ;
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      eq_cmult_conj u_cmult (
         .i_clk (s_axis_aclk_0),
         .i_rst (s_axis_areset_0),
         .i_en  (w_payload),
         .i_x   (w_x[k]),
         .i_h   (r_h),
         .o_y   (w_y[k])
      );
      assign m_axis_0_tdata[2*SW*k +: 2*SW] = w_y[k];
   end

   // Sideband follows the two-stage lane pipeline; only payload beats are valid.
   always_ff @(posedge s_axis_aclk_0 or posedge s_axis_areset_0) begin
      if (s_axis_areset_0) begin
         r_vld1  <= 1'b0;
         r_vld2  <= 1'b0;
         r_last1 <= 1'b0;
         r_last2 <= 1'b0;
         r_id1   <= '0;
         r_id2   <= '0;
         r_user1 <= '0;
         r_user2 <= '0;
      end else begin
         r_vld1  <= w_payload;
         r_vld2  <= r_vld1;
         r_last1 <= w_payload && s_axis_0_tlast;
         r_last2 <= r_last1;
         r_id1   <= s_axis_0_tid;
         r_id2   <= r_id1;
         r_user1 <= s_axis_0_tuser;
         r_user2 <= r_user1;
      end
   end

   assign m_axis_0_tvalid = r_vld2;
   assign m_axis_0_tlast  = r_last2;
   assign m_axis_0_tid    = r_id2;
   assign m_axis_0_tuser  = r_user2;
   assign eq_h            = r_h;
   assign eq_h_valid      = r_hValid;

endmodule

// File: tb/tb_design1_wrapper.sv
// Directed self-checking bench for design1_wrapper: training/estimate, payload
// equalization, saturation, short frames and asynchronous reset mid-payload.
module tb_design1_wrapper;

   localparam int TRAIN = 16;

   logic         clock = 1'b0;
   logic         reset;
   logic [127:0] sTdata;
   logic [7:0]   sTid;
   logic         sTlast;
   logic [7:0]   sTuser;
   logic         sTvalid;
   logic [127:0] mTdata;
   logic [7:0]   mTid;
   logic         mTlast;
   logic [7:0]   mTuser;
   logic         mTvalid;
   logic [31:0]  eqH;
   logic         eqHValid;

   int checks = 0;
   int errors = 0;

   logic         expValid [2];
   logic [127:0] expData  [2];
   logic         expLast  [2];
   logic [7:0]   expId    [2];
   logic [7:0]   expUser  [2];

   always #5 clock = ~clock;

   design1_wrapper dut (
      .s_axis_aclk_0   (clock),
      .s_axis_areset_0 (reset),
      .s_axis_0_tdata  (sTdata),
      .s_axis_0_tid    (sTid),
      .s_axis_0_tlast  (sTlast),
      .s_axis_0_tuser  (sTuser),
      .s_axis_0_tvalid (sTvalid),
      .m_axis_0_tdata  (mTdata),
      .m_axis_0_tid    (mTid),
      .m_axis_0_tlast  (mTlast),
      .m_axis_0_tuser  (mTuser),
      .m_axis_0_tvalid (mTvalid),
      .eq_h            (eqH),
      .eq_h_valid      (eqHValid)
   );

   function automatic logic [127:0] rep4(input logic [31:0] w);
      return {4{w}};
   endfunction

   task automatic checkVal(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Output seen now belongs to the beat driven two calls earlier.
   task automatic checkOutput();
      checkVal("out_tvalid", 128'(mTvalid), 128'(expValid[1]));
      if (expValid[1]) begin
         checkVal("out_tdata", mTdata, expData[1]);
         checkVal("out_tlast", 128'(mTlast), 128'(expLast[1]));
         checkVal("out_tid", 128'(mTid), 128'(expId[1]));
         checkVal("out_tuser", 128'(mTuser), 128'(expUser[1]));
      end
   endtask

   task automatic clearExpected();
      for (int i = 0; i < 2; i++) begin
         expValid[i] = 1'b0;
         expData[i]  = '0;
         expLast[i]  = 1'b0;
         expId[i]    = '0;
         expUser[i]  = '0;
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [127:0] d, input logic l,
                                input logic [7:0] id, input logic [7:0] user,
                                input logic eV, input logic [127:0] eD);
      @(negedge clock);
      checkOutput();
      expValid[1] = expValid[0];
      expData[1]  = expData[0];
      expLast[1]  = expLast[0];
      expId[1]    = expId[0];
      expUser[1]  = expUser[0];
      expValid[0] = eV;
      expData[0]  = eD;
      expLast[0]  = l & eV;
      expId[0]    = id;
      expUser[0]  = user;
      sTvalid = v;
      sTdata  = d;
      sTlast  = l;
      sTid    = id;
      sTuser  = user;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 8'h00, 8'h00, 1'b0, '0);
      end
   endtask

   task automatic sendFrame(input logic [127:0] trainData, input logic [127:0] payData,
                            input int nPay, input logic [127:0] expOut,
                            input logic [31:0] expH, input logic [7:0] id, input logic withLast);
      for (int j = 0; j < TRAIN; j++) begin
         applyStimulus(1'b1, trainData, 1'b0, id, 8'(j), 1'b0, '0);
      end
      for (int j = 0; j < nPay; j++) begin
         applyStimulus(1'b1, payData, withLast && (j == nPay - 1), id, 8'(j + TRAIN), 1'b1, expOut);
         if (j == 0) begin
            checkVal("eq_h_after_train", 128'(eqH), 128'(expH));
            checkVal("eq_h_valid_after_train", 128'(eqHValid), 128'(1'b1));
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      sTvalid = 1'b0;
      sTdata  = '0;
      sTlast  = 1'b0;
      sTid    = '0;
      sTuser  = '0;
      clearExpected();
      repeat (2) @(negedge clock);
      checkVal("reset_tvalid", 128'(mTvalid), 128'(1'b0));
      checkVal("reset_tdata", mTdata, '0);
      checkVal("reset_tlast", 128'(mTlast), 128'(1'b0));
      checkVal("reset_eq_h", 128'(eqH), '0);
      checkVal("reset_eq_h_valid", 128'(eqHValid), 128'(1'b0));
      reset = 1'b0;

      // tlast without tvalid must not disturb the counter or estimate.
      applyStimulus(1'b0, rep4(32'h000003E8), 1'b1, 8'h11, 8'h22, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, 8'h00, 8'h00, 1'b0, '0);
      checkVal("idle_tlast_eq_h", 128'(eqH), '0);
      checkVal("idle_tlast_eq_h_valid", 128'(eqHValid), 128'(1'b0));

      // h = 1000+0j; 16384 * 1000 >>> 15 = 500.
      sendFrame(rep4(32'h000003E8), rep4(32'h00004000), 304, rep4(32'h000001F4),
                32'h000003E8, 8'hA1, 1'b1);
      idle(2);

      // h = 0+1000j; yQ = floor(-1000000 / 32768) = -31.
      sendFrame(rep4(32'h03E80000), rep4(32'h000003E8), 4, rep4(32'hFFE10000),
                32'h03E80000, 8'hB2, 1'b1);
      // Back-to-back: h = -32768-32768j; yI saturates, yQ = 0.
      sendFrame(rep4(32'h80008000), rep4(32'h80008000), 3, rep4(32'h00007FFF),
                32'h80008000, 8'hC3, 1'b1);

      // Short frame: tlast on the 5th training beat.
      for (int j = 0; j < 5; j++) begin
         applyStimulus(1'b1, rep4(32'h000007D0), (j == 4), 8'hD4, 8'(j), 1'b0, '0);
      end
      idle(2);
      checkVal("short_frame_eq_h", 128'(eqH), 128'(32'h80008000));
      checkVal("short_frame_eq_h_valid", 128'(eqHValid), 128'(1'b1));

      // Distinct lanes: averages to 4000+0j; outputs 1000, 1000j, -1000, 12.
      sendFrame({32'h00000FA0, 32'h00000FA0, 32'h00001388, 32'h00000BB8},
                {32'h00000064, 32'h0000E000, 32'h20000000, 32'h00002000}, 4,
                {32'h0000000C, 32'h0000FC18, 32'h03E80000, 32'h000003E8},
                32'h00000FA0, 8'hE5, 1'b1);
      idle(2);

      // Reset asserted between edges while payload is in flight.
      sendFrame(rep4(32'h000003E8), rep4(32'h00004000), 5, rep4(32'h000001F4),
                32'h000003E8, 8'hF6, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkVal("midreset_tvalid", 128'(mTvalid), 128'(1'b0));
      checkVal("midreset_tdata", mTdata, '0);
      checkVal("midreset_eq_h", 128'(eqH), '0);
      checkVal("midreset_eq_h_valid", 128'(eqHValid), 128'(1'b0));
      sTvalid = 1'b0;
      sTlast  = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      clearExpected();
      idle(2);

      sendFrame(rep4(32'h000003E8), rep4(32'h00004000), 2, rep4(32'h000001F4),
                32'h000003E8, 8'h5A, 1'b1);
      idle(3);
      checkVal("final_eq_h", 128'(eqH), 128'(32'h000003E8));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/design1_wrapper.md
Name: design1_wrapper

Overview:
- Streaming single-tap complex channel equalizer on a 4-sample-per-beat AXI-Stream IQ path.
- Each frame starts with a training field. The block averages those samples into a channel estimate h.
- It then multiplies every payload sample by conj(h), scales, saturates, and emits the result on an output AXI-Stream.
- Sits between the receive sample front-end and downstream demodulation.

Parameters:
- LANES, 4, complex samples per beat.
- SW, 16, signed bit width of each I and Q component.
- TRAIN_BEATS, 16, training beats at the start of each frame (64 samples; must be a power of two).
- OUT_SHIFT, 15, arithmetic right shift applied to product sums.

Ports:
- s_axis_aclk_0  in  1  sole clock, rising edge.
- s_axis_areset_0  in  1  reset, asynchronous, active-high.
- s_axis_0_tdata  in  128  lane k: I at [32k+15:32k], Q at [32k+31:32k+16], two's complement.
- s_axis_0_tid  in  8  stream id, passed through.
- s_axis_0_tlast  in  1  last beat of frame.
- s_axis_0_tuser  in  8  user sideband, passed through.
- s_axis_0_tvalid  in  1  beat valid. There is no tready; the block always accepts input.
- m_axis_0_tdata  out  128  equalized samples, same lane packing as the input.
- m_axis_0_tid  out  8  delayed copy of tid.
- m_axis_0_tlast  out  1  delayed copy of tlast.
- m_axis_0_tuser  out  8  delayed copy of tuser.
- m_axis_0_tvalid  out  1  output beat valid. There is no tready; downstream must always accept.
- eq_h  out  32  current estimate: {hQ[15:0], hI[15:0]}.
- eq_h_valid  out  1  high once a full training field has been averaged.

Behaviour:
- Reset: all outputs 0; beat counter 0; accumulators 0; h = 0+0j; eq_h_valid = 0. The pipeline is flushed.
- Handshake:
  - A beat is consumed only when tvalid = 1.
  - tlast while tvalid = 0 is ignored.
- Beat counter:
  - Counts valid beats within a frame.
  - Clears to 0 after a valid beat carrying tlast.
  - Saturates at TRAIN_BEATS, so frames of any length are handled.
- Training phase (counter < TRAIN_BEATS):
  - Accumulate I and Q separately over all LANES*TRAIN_BEATS samples in 23-bit signed accumulators.
  - Training beats produce no output (m_axis_0_tvalid stays 0).
- Estimate update:
  - On the cycle after the last training beat, h = accumulator >>> log2(LANES*TRAIN_BEATS) (arithmetic, floor).
  - eq_h_valid is then set to 1 and accumulators clear.
- Payload phase (counter >= TRAIN_BEATS), per lane:
  - yI = sat16((xI*hI + xQ*hQ) >>> OUT_SHIFT).
  - yQ = sat16((xQ*hI - xI*hQ) >>> OUT_SHIFT).
  - Products are 32-bit signed and sums 33-bit. The shift is arithmetic (floor, no rounding). Saturation is to [-32768, 32767].
- Latency: 2 clocks from input beat to output beat.
  - Stage 1 registers the four products per lane.
  - Stage 2 registers the sum, shift and saturation.
  - tid, tuser, tlast and tvalid are delayed identically.
- h in use: payload beats use the most recent h. If eq_h_valid = 0, h = 0 and outputs are 0.
- Short frame (tlast during training):
  - Training is aborted and accumulators clear.
  - h and eq_h_valid keep their previous values.
  - No output beats are produced.
- Back-to-back frames: a training beat may immediately follow a tlast beat with no idle cycle.
- Reset mid-frame: takes effect immediately and asynchronously; in-flight beats are discarded.

Decomposition:
- Package eq_pkg:
  - LANES, SW, ACC_W = 23, PROD_W = 32.
  - typedef cplx_t struct {logic signed [SW-1:0] q, i}.
  - typedef beat_t cplx_t [LANES].
  - sat16 function.
- Sub-module eq_cmult_conj: one lane computing x*conj(h) with the 2-stage pipeline, shift and saturation. Instantiate LANES times.
- The top level holds the beat counter, accumulators, h register and sideband pipeline.

Test Plan:
- Training, all samples 1000+0j (16 beats); payload 16384+0j, 304 beats, tlast on beat 319 -> eq_h = 0x000003E8, eq_h_valid = 1; 304 output beats, each lane 500+0j; m_axis_0_tlast on the last output beat; latency 2 clocks.
- Training all 0+1000j; payload 1000+0j -> each output lane 0 - 31j (floor of -30.5).
- Training all -32768-32768j; payload -32768-32768j -> yI saturates to 32767, yQ = 0.
- Idle tlast pulse with tvalid = 0 before the frame -> no state change; counter stays 0.
- Frame tlast on beat 5 after a valid first frame -> h unchanged, no output; next full frame equalizes with a fresh estimate.
- Assert reset mid-payload -> outputs, h and eq_h_valid go to 0 immediately; the following frame re-trains normally.
